id_ex_stage: RTL and testbench

//  ID/EX pipeline register with built-in load-use hazard detection. Captures decoded control
//  (incl. ALUOp) and operands from ID; drives EX, where ALUOp + FuncCode feed ALUController.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/load_use_detect.sv | 36 +++
 rtl/id_ex_stage.sv | 173 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
//   Shared pipeline definitions for the ID/EX stage and its consumers.
//   - alu_op_e  : ALUOp encodings seen by the ALU controller
//   - ex_ctl_t  : control bits carried from ID into EX
//   - EX_BUBBLE : all-zero control word (no valid instruction, no side effects)
// ----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
    } ex_ctl_t;

    localparam ex_ctl_t EX_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// ----------------------------------------------------------------------------
// load_use_detect
//   Combinational load-use hazard compare between the load sitting in EX and
//   the instruction currently in ID.
//   Ports:
//     ex_valid, ex_mem_read, ex_rt  : instruction in EX (load destination = Rt)
//     id_valid, id_uses_rs/rt       : instruction in ID and which sources it reads
//     id_rs, id_rt                  : ID source specifiers
//     load_use                      : ID needs the loaded value next cycle
// ----------------------------------------------------------------------------
module load_use_detect #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              id_valid,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              load_use
);

    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit   = id_uses_rs && (id_rs == ex_rt);
        rt_hit   = id_uses_rt && (id_rt == ex_rt);
        // Register 0 is hard-wired, so a load into it never creates a dependency.
        load_use = ex_valid && ex_mem_read && (ex_rt != '0) && id_valid
                   && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with load-use hazard detection.
//   Inputs : Id* decoded control, specifiers and operands; Hold (downstream
//            freeze); Flush (taken branch kills the ID instruction).
//   Outputs: Ex* registered copies (ExFuncCode = ExImm[5:0]); StallReq
//            (combinational, freezes PC and IF/ID); BubbleCnt (saturating
//            count of load-use bubbles).
//   Edge priority: Flush > Hold > LoadUse > normal load.
// ----------------------------------------------------------------------------
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              IdValid,
    input  logic              IdRegWrite,
    input  logic              IdMemRead,
    input  logic              IdMemWrite,
    input  logic              IdMemtoReg,
    input  logic              IdBranch,
    input  logic              IdRegDst,
    input  logic              IdALUSrc,
    input  logic [1:0]        IdALUOp,
    input  logic              IdUsesRs,
    input  logic              IdUsesRt,
    input  logic [REG_AW-1:0] IdRs,
    input  logic [REG_AW-1:0] IdRt,
    input  logic [REG_AW-1:0] IdRd,
    input  logic [DATA_W-1:0] IdRD1,
    input  logic [DATA_W-1:0] IdRD2,
    input  logic [DATA_W-1:0] IdImm,
    input  logic [DATA_W-1:0] IdPC4,
    input  logic              Hold,
    input  logic              Flush,
    output logic              ExValid,
    output logic              ExRegWrite,
    output logic              ExMemRead,
    output logic              ExMemWrite,
    output logic              ExMemtoReg,
    output logic              ExBranch,
    output logic              ExRegDst,
    output logic              ExALUSrc,
    output logic [1:0]        ExALUOp,
    output logic [5:0]        ExFuncCode,
    output logic [REG_AW-1:0] ExRs,
    output logic [REG_AW-1:0] ExRt,
    output logic [REG_AW-1:0] ExRd,
    output logic [DATA_W-1:0] ExRD1,
    output logic [DATA_W-1:0] ExRD2,
    output logic [DATA_W-1:0] ExImm,
    output logic [DATA_W-1:0] ExPC4,
    output logic              StallReq,
    output logic [CNT_W-1:0]  BubbleCnt
);

    ex_ctl_t             ctl_q, ctl_d;
    ex_ctl_t             id_ctl;
    ex_ctl_t             bubble_ctl;
    logic [REG_AW-1:0]   rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc4_q, pc4_d;
    logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;
    logic                load_use;
    logic                load_fields;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .ex_valid    (ctl_q.valid),
        .ex_mem_read (ctl_q.mem_read),
        .ex_rt       (rt_q),
        .id_valid    (IdValid),
        .id_uses_rs  (IdUsesRs),
        .id_uses_rt  (IdUsesRt),
        .id_rs       (IdRs),
        .id_rt       (IdRt),
        .load_use    (load_use)
    );

    // A flush overrides both hold and the hazard, so it never asks for a stall.
    assign StallReq = !Flush && (Hold || load_use);

    always_comb begin
        id_ctl = '{valid:      IdValid,
                   reg_write:  IdRegWrite,
                   mem_read:   IdMemRead,
                   mem_write:  IdMemWrite,
                   mem_to_reg: IdMemtoReg,
                   branch:     IdBranch,
                   reg_dst:    IdRegDst,
                   alu_src:    IdALUSrc,
                   alu_op:     IdALUOp};

        // Bubble clears every side-effecting bit; RegDst/ALUSrc only steer
        // muxes, so they follow ID like the data fields.
        bubble_ctl         = EX_BUBBLE;
        bubble_ctl.reg_dst = IdRegDst;
        bubble_ctl.alu_src = IdALUSrc;

        ctl_d        = ctl_q;
        bubble_cnt_d = bubble_cnt_q;
        load_fields  = Flush || !Hold;

        if (Flush) begin
            ctl_d = bubble_ctl;
        end else if (Hold) begin
            ctl_d = ctl_q;
        end else if (load_use) begin
            ctl_d = bubble_ctl;
            if (bubble_cnt_q != '1) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else begin
            ctl_d = id_ctl;
        end

        rs_d  = load_fields ? IdRs  : rs_q;
        rt_d  = load_fields ? IdRt  : rt_q;
        rd_d  = load_fields ? IdRd  : rd_q;
        rd1_d = load_fields ? IdRD1 : rd1_q;
        rd2_d = load_fields ? IdRD2 : rd2_q;
        imm_d = load_fields ? IdImm : imm_q;
        pc4_d = load_fields ? IdPC4 : pc4_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q        <= EX_BUBBLE;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            pc4_q        <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ctl_q        <= ctl_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            pc4_q        <= pc4_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ExValid    = ctl_q.valid;
    assign ExRegWrite = ctl_q.reg_write;
    assign ExMemRead  = ctl_q.mem_read;
    assign ExMemWrite = ctl_q.mem_write;
    assign ExMemtoReg = ctl_q.mem_to_reg;
    assign ExBranch   = ctl_q.branch;
    assign ExRegDst   = ctl_q.reg_dst;
    assign ExALUSrc   = ctl_q.alu_src;
    assign ExALUOp    = ctl_q.alu_op;
    assign ExFuncCode = imm_q[5:0];
    assign ExRs       = rs_q;
    assign ExRt       = rt_q;
    assign ExRd       = rd_q;
    assign ExRD1      = rd1_q;
    assign ExRD2      = rd2_q;
    assign ExImm      = imm_q;
    assign ExPC4      = pc4_q;
    assign BubbleCnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed, table-driven bench for id_ex_stage. A second instance with a
//   2-bit bubble counter shares the stimulus and is used for saturation.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    // Control word order: {RegWrite, MemRead, MemWrite, MemtoReg, Branch, RegDst, ALUSrc, ALUOp}
    localparam logic [8:0] C_LW   = 9'b110100100;
    localparam logic [8:0] C_ADD  = 9'b100001010;
    localparam logic [8:0] C_SW   = 9'b001000100;
    localparam logic [8:0] C_BEQ  = 9'b000010001;
    localparam logic [8:0] C_ADDI = 9'b100000100;
    // Expected EX word = {Valid, control word}; bubbles keep only RegDst/ALUSrc
    localparam logic [9:0] B_ADD  = 10'b0000001000;
    localparam logic [9:0] B_SW   = 10'b0000000100;
    localparam logic [9:0] B_BEQ  = 10'b0000000000;

    typedef struct {
        logic        v;
        logic [8:0]  ctl;
        logic        urs, urt;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm;
        logic        hold, flush;
        logic        e_stall;
        logic [9:0]  e_ctl;
        logic [14:0] e_regs;
        logic [31:0] e_imm;
        logic [15:0] e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        IdValid, IdRegWrite, IdMemRead, IdMemWrite, IdMemtoReg, IdBranch;
    logic        IdRegDst, IdALUSrc, IdUsesRs, IdUsesRt, Hold, Flush;
    logic [1:0]  IdALUOp;
    logic [4:0]  IdRs, IdRt, IdRd;
    logic [31:0] IdRD1, IdRD2, IdImm, IdPC4;

    logic        ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemtoReg, ExBranch;
    logic        ExRegDst, ExALUSrc, StallReq;
    logic [1:0]  ExALUOp;
    logic [5:0]  ExFuncCode;
    logic [4:0]  ExRs, ExRt, ExRd;
    logic [31:0] ExRD1, ExRD2, ExImm, ExPC4;
    logic [15:0] BubbleCnt;

    logic        s_ExValid, s_ExRegWrite, s_ExMemRead, s_ExMemWrite, s_ExMemtoReg, s_ExBranch;
    logic        s_ExRegDst, s_ExALUSrc, s_StallReq;
    logic [1:0]  s_ExALUOp;
    logic [5:0]  s_ExFuncCode;
    logic [4:0]  s_ExRs, s_ExRt, s_ExRd;
    logic [31:0] s_ExRD1, s_ExRD2, s_ExImm, s_ExPC4;
    logic [1:0]  s_BubbleCnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    vec_t        vecs[$];

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .IdValid(IdValid), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
        .IdMemWrite(IdMemWrite), .IdMemtoReg(IdMemtoReg), .IdBranch(IdBranch),
        .IdRegDst(IdRegDst), .IdALUSrc(IdALUSrc), .IdALUOp(IdALUOp),
        .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt),
        .IdRs(IdRs), .IdRt(IdRt), .IdRd(IdRd),
        .IdRD1(IdRD1), .IdRD2(IdRD2), .IdImm(IdImm), .IdPC4(IdPC4),
        .Hold(Hold), .Flush(Flush),
        .ExValid(ExValid), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
        .ExMemWrite(ExMemWrite), .ExMemtoReg(ExMemtoReg), .ExBranch(ExBranch),
        .ExRegDst(ExRegDst), .ExALUSrc(ExALUSrc), .ExALUOp(ExALUOp),
        .ExFuncCode(ExFuncCode), .ExRs(ExRs), .ExRt(ExRt), .ExRd(ExRd),
        .ExRD1(ExRD1), .ExRD2(ExRD2), .ExImm(ExImm), .ExPC4(ExPC4),
        .StallReq(StallReq), .BubbleCnt(BubbleCnt)
    );

    id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .IdValid(IdValid), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
        .IdMemWrite(IdMemWrite), .IdMemtoReg(IdMemtoReg), .IdBranch(IdBranch),
        .IdRegDst(IdRegDst), .IdALUSrc(IdALUSrc), .IdALUOp(IdALUOp),
        .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt),
        .IdRs(IdRs), .IdRt(IdRt), .IdRd(IdRd),
        .IdRD1(IdRD1), .IdRD2(IdRD2), .IdImm(IdImm), .IdPC4(IdPC4),
        .Hold(Hold), .Flush(Flush),
        .ExValid(s_ExValid), .ExRegWrite(s_ExRegWrite), .ExMemRead(s_ExMemRead),
        .ExMemWrite(s_ExMemWrite), .ExMemtoReg(s_ExMemtoReg), .ExBranch(s_ExBranch),
        .ExRegDst(s_ExRegDst), .ExALUSrc(s_ExALUSrc), .ExALUOp(s_ExALUOp),
        .ExFuncCode(s_ExFuncCode), .ExRs(s_ExRs), .ExRt(s_ExRt), .ExRd(s_ExRd),
        .ExRD1(s_ExRD1), .ExRD2(s_ExRD2), .ExImm(s_ExImm), .ExPC4(s_ExPC4),
        .StallReq(s_StallReq), .BubbleCnt(s_BubbleCnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [8:0] ctl, input logic urs,
                                input logic urt, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] imm,
                                input logic hold, input logic flush, input logic e_stall,
                                input logic [9:0] e_ctl, input logic [14:0] e_regs,
                                input logic [31:0] e_imm, input logic [15:0] e_cnt);
        vec_t r;
        r.v = v; r.ctl = ctl; r.urs = urs; r.urt = urt;
        r.rs = rs; r.rt = rt; r.rd = rd; r.imm = imm;
        r.hold = hold; r.flush = flush; r.e_stall = e_stall;
        r.e_ctl = e_ctl; r.e_regs = e_regs; r.e_imm = e_imm; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [8:0] ctl, input logic urs, input logic urt,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] imm, input logic hold, input logic flush);
        IdValid = v;
        {IdRegWrite, IdMemRead, IdMemWrite, IdMemtoReg, IdBranch, IdRegDst, IdALUSrc, IdALUOp} = ctl;
        IdUsesRs = urs; IdUsesRt = urt;
        IdRs = rs; IdRt = rt; IdRd = rd;
        IdImm = imm; IdRD1 = imm + 32'h1000_0001; IdRD2 = imm + 32'h2000_0002;
        IdPC4 = imm + 32'h0040_0004;
        Hold = hold; Flush = flush;
    endtask

    function automatic logic [9:0] ex_ctl();
        return {ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemtoReg, ExBranch,
                ExRegDst, ExALUSrc, ExALUOp};
    endfunction

    initial begin
        //          v  ctl     urs urt rs  rt  rd  imm     hld fl  stall e_ctl           e_regs            e_imm   cnt
        vecs.push_back(mk(1, C_ADD,  1, 1, 1,  2,  3, 32'h20, 0, 0, 0, {1'b1, C_ADD},  {5'd1, 5'd2, 5'd3}, 32'h20, 0));
        vecs.push_back(mk(1, C_LW,   1, 0, 9,  8,  0, 32'h10, 0, 0, 0, {1'b1, C_LW},   {5'd9, 5'd8, 5'd0}, 32'h10, 0));
        vecs.push_back(mk(1, C_ADD,  1, 1, 8,  2,  4, 32'h20, 0, 0, 1, B_ADD,          {5'd8, 5'd2, 5'd4}, 32'h20, 1));
        vecs.push_back(mk(1, C_ADD,  1, 1, 8,  2,  4, 32'h20, 0, 0, 0, {1'b1, C_ADD},  {5'd8, 5'd2, 5'd4}, 32'h20, 1));
        vecs.push_back(mk(1, C_LW,   1, 0, 1,  0,  0, 32'h04, 0, 0, 0, {1'b1, C_LW},   {5'd1, 5'd0, 5'd0}, 32'h04, 1));
        vecs.push_back(mk(1, C_ADD,  1, 1, 0,  0,  5, 32'h22, 0, 0, 0, {1'b1, C_ADD},  {5'd0, 5'd0, 5'd5}, 32'h22, 1));
        vecs.push_back(mk(1, C_LW,   1, 0, 2,  7,  0, 32'h08, 0, 0, 0, {1'b1, C_LW},   {5'd2, 5'd7, 5'd0}, 32'h08, 1));
        vecs.push_back(mk(1, C_ADDI, 0, 0, 7,  7,  0, 32'h05, 0, 0, 0, {1'b1, C_ADDI}, {5'd7, 5'd7, 5'd0}, 32'h05, 1));
        vecs.push_back(mk(1, C_LW,   1, 0, 3,  6,  0, 32'h0C, 0, 0, 0, {1'b1, C_LW},   {5'd3, 5'd6, 5'd0}, 32'h0C, 1));
        vecs.push_back(mk(0, 9'h0,   1, 0, 6,  0,  0, 32'h00, 0, 0, 0, 10'h0,          {5'd6, 5'd0, 5'd0}, 32'h00, 1));
        vecs.push_back(mk(1, C_LW,   1, 0, 1,  9,  0, 32'h30, 0, 0, 0, {1'b1, C_LW},   {5'd1, 5'd9, 5'd0}, 32'h30, 1));
        vecs.push_back(mk(1, C_SW,   1, 1, 2,  9,  0, 32'h14, 0, 0, 1, B_SW,           {5'd2, 5'd9, 5'd0}, 32'h14, 2));
        vecs.push_back(mk(1, C_SW,   1, 1, 2,  9,  0, 32'h14, 0, 0, 0, {1'b1, C_SW},   {5'd2, 5'd9, 5'd0}, 32'h14, 2));
        vecs.push_back(mk(1, C_BEQ,  1, 1, 1,  2,  0, 32'h03, 0, 1, 0, B_BEQ,          {5'd1, 5'd2, 5'd0}, 32'h03, 2));
        vecs.push_back(mk(1, C_LW,   1, 0, 1,  8,  0, 32'h40, 0, 0, 0, {1'b1, C_LW},   {5'd1, 5'd8, 5'd0}, 32'h40, 2));
        vecs.push_back(mk(1, C_ADD,  1, 1, 8,  2,  3, 32'h20, 1, 0, 1, {1'b1, C_LW},   {5'd1, 5'd8, 5'd0}, 32'h40, 2));
        vecs.push_back(mk(1, C_ADD,  1, 1, 8,  2,  3, 32'h20, 1, 0, 1, {1'b1, C_LW},   {5'd1, 5'd8, 5'd0}, 32'h40, 2));
        vecs.push_back(mk(1, C_ADD,  1, 1, 8,  2,  3, 32'h20, 1, 0, 1, {1'b1, C_LW},   {5'd1, 5'd8, 5'd0}, 32'h40, 2));
        vecs.push_back(mk(1, C_ADD,  1, 1, 8,  2,  3, 32'h20, 1, 1, 0, B_ADD,          {5'd8, 5'd2, 5'd3}, 32'h20, 2));
        vecs.push_back(mk(1, C_LW,   1, 0, 1,  8,  0, 32'h40, 0, 0, 0, {1'b1, C_LW},   {5'd1, 5'd8, 5'd0}, 32'h40, 2));
        vecs.push_back(mk(1, C_ADD,  1, 1, 8,  2,  3, 32'h20, 0, 1, 0, B_ADD,          {5'd8, 5'd2, 5'd3}, 32'h20, 2));

        rst_n = 1'b0;
        drive(0, 9'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        #1;
        check("reset_ctl", 64'(ex_ctl()), 64'h0);
        check("reset_cnt", 64'(BubbleCnt), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].ctl, vecs[i].urs, vecs[i].urt, vecs[i].rs, vecs[i].rt,
                  vecs[i].rd, vecs[i].imm, vecs[i].hold, vecs[i].flush);
            #1;
            check($sformatf("v%0d_stall", i), 64'(StallReq), 64'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ctl", i), 64'(ex_ctl()), 64'(vecs[i].e_ctl));
            check($sformatf("v%0d_regs", i), 64'({ExRs, ExRt, ExRd}), 64'(vecs[i].e_regs));
            check($sformatf("v%0d_imm", i), 64'(ExImm), 64'(vecs[i].e_imm));
            check($sformatf("v%0d_func", i), 64'(ExFuncCode), 64'(vecs[i].e_imm[5:0]));
            check($sformatf("v%0d_rd1", i), 64'(ExRD1), 64'(vecs[i].e_imm + 32'h1000_0001));
            check($sformatf("v%0d_rd2", i), 64'(ExRD2), 64'(vecs[i].e_imm + 32'h2000_0002));
            check($sformatf("v%0d_pc4", i), 64'(ExPC4), 64'(vecs[i].e_imm + 32'h0040_0004));
            check($sformatf("v%0d_cnt", i), 64'(BubbleCnt), 64'(vecs[i].e_cnt));
        end

        // Asynchronous reset in the middle of a load-use stall
        @(negedge clk);
        drive(1, C_LW, 1, 0, 1, 8, 0, 32'h40, 0, 0);
        @(negedge clk);
        drive(1, C_ADD, 1, 1, 8, 2, 3, 32'h20, 0, 0);
        #1;
        check("midrst_pre_stall", 64'(StallReq), 64'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_ctl", 64'(ex_ctl()), 64'h0);
        check("midrst_regs", 64'({ExRs, ExRt, ExRd}), 64'h0);
        check("midrst_data", 64'(ExRD1 | ExRD2 | ExImm | ExPC4), 64'h0);
        check("midrst_cnt", 64'(BubbleCnt), 64'h0);
        check("midrst_stall", 64'(StallReq), 64'h0);
        @(negedge clk);
        drive(0, 9'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        rst_n = 1'b1;

        // Five load-use hazards: 16-bit counter reaches 5, 2-bit counter sticks at 3
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1, C_LW, 1, 0, 1, 8, 0, 32'h40, 0, 0);
            @(negedge clk);
            drive(1, C_ADD, 1, 1, 8, 2, 3, 32'h20, 0, 0);
            #1;
            check($sformatf("sat%0d_stall", k), 64'(StallReq), 64'h1);
            @(negedge clk);
            #1;
            check($sformatf("sat%0d_nostall", k), 64'(StallReq), 64'h0);
            @(posedge clk);
            #1;
            check($sformatf("sat%0d_cnt2", k), 64'(s_BubbleCnt), 64'((k + 1 > 3) ? 3 : k + 1));
        end
        check("sat_cnt16", 64'(BubbleCnt), 64'h5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
